// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for a single-cycle core.
// It provides a word-addressed RAM with a combinational read path.
// It also provides an MMIO window that holds a TX byte FIFO, its status register and a free-running cycle counter.
module dm_responder #(
   parameter int unsigned            WORD_SIZE  = 32,
   parameter int unsigned            RAM_WORDS  = 256,
   parameter int unsigned            FIFO_DEPTH = 8,
   parameter logic [WORD_SIZE-1:0]   MMIO_BASE  = 32'hFFFF_FF00
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [WORD_SIZE-1:0] i_DM_addr,
   input  logic [WORD_SIZE-1:0] i_DM_wd,
   input  logic                 i_DM_wen,
   input  logic                 i_DM_ren,
   output logic [WORD_SIZE-1:0] o_DM_rd,
   output logic                 o_tx_valid,
   output logic [7:0]           o_tx_data,
   input  logic                 i_tx_ready
);

   localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
   localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = FIFO_AW + 1;

   localparam logic [7:0] OFF_TXDATA = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_CYCLE  = 8'h08;

   // Storage: RAM and FIFO bodies are never reset.
   logic [WORD_SIZE-1:0] ram_q  [RAM_WORDS];
   logic [7:0]           fifo_q [FIFO_DEPTH];

   // Control state
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic [WORD_SIZE-1:0] cycle_q, cycle_d;

   // Decode and handshake terms
   logic                 is_mmio_s;
   logic [7:0]           mmio_off_s;
   logic [RAM_AW-1:0]    ram_idx_s;
   logic                 ram_we_s;
   logic                 push_req_s;
   logic                 stat_wr_s;
   logic                 cyc_wr_s;
   logic                 empty_s;
   logic                 full_s;
   logic                 pop_s;
   logic                 push_ok_s;
   logic [WORD_SIZE-1:0] status_s;
   logic [WORD_SIZE-1:0] rd_s;

   // Address decode: the MMIO window is matched on the upper address bits; everything else aliases into RAM.
   always_comb begin
      is_mmio_s  = (i_DM_addr[WORD_SIZE-1:8] == MMIO_BASE[WORD_SIZE-1:8]);
      mmio_off_s = i_DM_addr[7:0];
      ram_idx_s  = i_DM_addr[RAM_AW+1:2];
      ram_we_s   = i_DM_wen & ~is_mmio_s;
      push_req_s = i_DM_wen & is_mmio_s & (mmio_off_s == OFF_TXDATA);
      stat_wr_s  = i_DM_wen & is_mmio_s & (mmio_off_s == OFF_STATUS);
      cyc_wr_s   = i_DM_wen & is_mmio_s & (mmio_off_s == OFF_CYCLE);
   end

   // FIFO / overflow / cycle next-state.
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push when the head is drained.
   always_comb begin
      empty_s   = (count_q == {CNT_W{1'b0}});
      full_s    = (count_q == CNT_W'(FIFO_DEPTH));
      pop_s     = ~empty_s & i_tx_ready;
      push_ok_s = push_req_s & (~full_s | pop_s);

      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A dropped byte wins over a same-cycle clear so the loss is never hidden.
      if (push_req_s & full_s & ~pop_s) begin
         overflow_d = 1'b1;
      end else if (stat_wr_s & i_DM_wd[2]) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end

      if (cyc_wr_s) begin
         cycle_d = i_DM_wd;
      end else begin
         cycle_d = cycle_q + WORD_SIZE'(1);
      end
   end

   // Control registers with synchronous active-high reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= {FIFO_AW{1'b0}};
         rd_ptr_q   <= {FIFO_AW{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
         cycle_q    <= {WORD_SIZE{1'b0}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         cycle_q    <= cycle_d;
      end
   end

   // FIFO body write; contents beyond count are don't-care, so no reset is needed.
   always_ff @(posedge i_clk) begin
      if (push_ok_s & ~i_rst) begin
         fifo_q[wr_ptr_q] <= i_DM_wd[7:0];
      end
   end

   // RAM write port; reset deliberately leaves contents alone.
   always_ff @(posedge i_clk) begin
      if (ram_we_s) begin
         ram_q[ram_idx_s] <= i_DM_wd;
      end
   end

   // Read mux: combinational and side-effect free; returns zero when no read is requested.
   always_comb begin
      status_s              = {WORD_SIZE{1'b0}};
      status_s[0]           = empty_s;
      status_s[1]           = full_s;
      status_s[2]           = overflow_q;
      status_s[8 +: CNT_W]  = count_q;

      if (!i_DM_ren) begin
         rd_s = {WORD_SIZE{1'b0}};
      end else if (is_mmio_s) begin
         case (mmio_off_s)
            OFF_STATUS: rd_s = status_s;
            OFF_CYCLE:  rd_s = cycle_q;
            default:    rd_s = {WORD_SIZE{1'b0}};
         endcase
      end else begin
         rd_s = ram_q[ram_idx_s];
      end
   end

   assign o_DM_rd    = rd_s;
   assign o_tx_valid = ~empty_s;
   assign o_tx_data  = empty_s ? 8'h00 : fifo_q[rd_ptr_q];

endmodule
